// File: rtl/da2_dac_rx.sv
// da2_dac_rx: oversampling receiver for the Pmod DA2 serial frames (two DAC121S101).
// Optional build macro DA2_RX_STRICT_EN: reject frames whose don't-care bits 15:14 are nonzero.
module da2_dac_rx #(
  parameter int unsigned DUAL_MODE   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        SCK,
  input  logic        CS,
  input  logic        DA,
  input  logic        DB,
  output logic [11:0] data_a,
  output logic [11:0] data_b,
  output logic [1:0]  mode_a,
  output logic [1:0]  mode_b,
  output logic [11:0] vout_a,
  output logic [11:0] vout_b,
  output logic        update,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Bits 15:14 only matter when strict checking is built in; otherwise they
  // simply fall off the end of a 14-bit shifter with identical behaviour.
`ifdef DA2_RX_STRICT_EN
  localparam int unsigned SHIFT_W = 16;
`else
  localparam int unsigned SHIFT_W = 14;
`endif

  localparam logic [2:0] PRIME_CYC = 3'(SYNC_STAGES);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, da_sync, db_sync;
  logic sck_s, cs_s, da_s, db_s;
  logic sck_prev, cs_prev;
  logic sck_fall, cs_fall, cs_rise;
  logic [2:0] prime_cnt;
  logic armed;

  logic [SHIFT_W-1:0] shift_a, shift_b;
  logic [4:0] bit_cnt;
  logic do_shift, do_accept, do_abort, clr_cnt;
  logic reject;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign da_s  = da_sync[SYNC_STAGES-1];
  assign db_s  = db_sync[SYNC_STAGES-1];

  assign sck_fall = sck_prev & ~sck_s;
  assign cs_fall  = armed & cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;

`ifdef DA2_RX_STRICT_EN
  assign reject = (shift_a[15:14] != 2'b00) || (shift_b[15:14] != 2'b00);
`else
  assign reject = 1'b0;
`endif

  // Input synchronizers; reset to the idle line levels.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      da_sync  <= '0;
      db_sync  <= '0;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
      da_sync  <= {da_sync[SYNC_STAGES-2:0], DA};
      db_sync  <= {db_sync[SYNC_STAGES-2:0], DB};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  // Arm frame detection only once the synchronizers hold real line values and
  // CS has been seen high, so a frame already running at reset release is skipped.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      prime_cnt <= '0;
      armed     <= 1'b0;
    end else if (prime_cnt != PRIME_CYC) begin
      prime_cnt <= prime_cnt + 3'd1;
    end else if (cs_s) begin
      armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state and datapath strobes. A CS rise coinciding with the 16th SCK
  // fall is not an abort: the fall completes the frame first.
  always_comb begin
    state_next = state;
    do_shift   = 1'b0;
    do_accept  = 1'b0;
    do_abort   = 1'b0;
    clr_cnt    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          clr_cnt    = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt == 5'd16) begin
          do_accept  = 1'b1;
          state_next = DONE;
        end else begin
          do_shift = sck_fall;
          if (cs_rise && !(sck_fall && bit_cnt == 5'd15)) begin
            do_abort   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter, latched outputs and status pulses.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      shift_a   <= '0;
      shift_b   <= '0;
      bit_cnt   <= '0;
      data_a    <= '0;
      data_b    <= '0;
      mode_a    <= '0;
      mode_b    <= '0;
      update    <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      if (clr_cnt) bit_cnt <= '0;
      if (do_shift) begin
        shift_a <= {shift_a[SHIFT_W-2:0], da_s};
        if (DUAL_MODE != 0) shift_b <= {shift_b[SHIFT_W-2:0], db_s};
        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
      end
      if (do_accept) begin
        if (reject) begin
          frame_err <= 1'b1;
        end else begin
          {mode_a, data_a} <= shift_a[13:0];
          if (DUAL_MODE != 0) {mode_b, data_b} <= shift_b[13:0];
          update    <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
      if (do_abort) frame_err <= 1'b1;
    end
  end

  // Effective DAC outputs: any power-down mode drives zero.
  always_comb begin
    vout_a = (mode_a == 2'b00) ? data_a : '0;
    vout_b = (mode_b == 2'b00) ? data_b : '0;
  end

endmodule

// File: doc/da2_dac_rx.md
Name: da2_dac_rx

Overview:
- Serial-side receiver that models the two DAC121S101 converters on a Pmod DA2.
- It decodes the SCK/CS/DA/DB frames produced by the DA2 AXI IP and presents the latched 12-bit codes and power-down modes per channel.
- It runs entirely on the system clock and oversamples the serial lines. It is used as a synthesizable loopback checker on-board and as a bench model.

Parameters:
- DUAL_MODE, 1, 1 = decode both DA and DB; 0 = DB ignored, channel B outputs held at reset values.
- SYNC_STAGES, 2, synchronizer depth for SCK/CS/DA/DB (legal range 2..4).

Ports:
- s_axi_aclk  in  1  system clock; SCK must be ≤ s_axi_aclk/4.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- SCK  in  1  serial clock from the DA2 IP.
- CS  in  1  frame sync, active-low.
- DA  in  1  serial data, channel A.
- DB  in  1  serial data, channel B.
- data_a  out  12  last accepted code, channel A.
- data_b  out  12  last accepted code, channel B.
- mode_a  out  2  last accepted power-down mode, channel A.
- mode_b  out  2  last accepted power-down mode, channel B.
- vout_a  out  12  effective output: data_a when mode_a==0, else 0.
- vout_b  out  12  same rule for channel B.
- update  out  1  one-cycle pulse when a frame is accepted.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- frame_cnt  out  16  count of accepted frames; wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous, active-low): every output is 0, shift registers are 0, the bit counter is 0, and the state is IDLE. Synchronizer flops reset to idle levels: SCK=1, CS=1, data=0.
- All four inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized SCK and CS (previous-value compare). A falling SCK is a 1→0 transition of synchronized SCK.
- State machine IDLE / SHIFT / DONE:
  - IDLE → SHIFT on synchronized CS falling; the bit counter clears.
  - SHIFT: on each SCK fall with CS low, shift_x <= {shift_x[14:0], Dx} and the counter increments.
  - SHIFT, counter reaches 16 (the 16th fall): in the next cycle, latch {mode_x, data_x} <= shift_x[13:0], pulse update, increment frame_cnt, go to DONE.
  - SHIFT, CS rises with counter < 16: frame aborted, outputs unchanged, frame_err pulses, go to IDLE.
  - DONE: further SCK falls are ignored. CS rise → IDLE, no pulse.
- Bit order: MSB first. Bits 15:14 are don't-care, 13:12 are the mode, 11:0 are the data.
- CS rising on the same synchronized cycle as the 16th SCK fall: the fall is counted first, so the frame is accepted (update, not frame_err).
- Counter width is 5 bits and saturates at 16.
- update and frame_err are never asserted in the same cycle.
- vout_x is combinational from the latched registers.
- Reset asserted mid-frame: immediate clear. A frame already in progress after reset release is not decoded until the next CS fall.
- Latency: update asserts SYNC_STAGES+2 cycles after the 16th raw SCK fall.

Optional Feature:
- Macro: DA2_RX_STRICT_EN.
- Defined: a frame whose bits 15:14 are nonzero on either decoded channel is rejected. Outputs stay unchanged, frame_cnt does not increment, and frame_err pulses in place of update.
- Undefined: bits 15:14 are ignored and frame_err fires only on abort.

Test Plan:
- Reset, then send a frame with SCK=10 MHz, clk=100 MHz, DA=0x001A, DB=0x0AF5 → data_a=0x01A, data_b=0xAF5, modes 0, one update pulse, frame_cnt=1.
- Frame DA=0x2BCA → mode_a=2, data_a=0xBCA, vout_a=0; vout_b retains its previous value.
- CS raised after 9 SCK falls → one frame_err pulse, no update, all outputs and frame_cnt unchanged.
- 20 SCK falls within one CS-low window, DA=0x0123 on the first 16 → data_a=0x123, exactly one update; extra edges ignored.
- DUAL_MODE=0 with DB toggling → data_b/mode_b stay 0, channel A decodes normally.
- Build with DA2_RX_STRICT_EN, send DA=0xC001 → frame_err pulses, data_a unchanged, frame_cnt unchanged. Build without the macro → data_a=0x001, update pulses.
